csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 187 ++++++++++++++++++
 tb/tb_csr_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// csr_unit
//   Machine-mode CSR file with trap entry and MRET for a single-issue pipeline
//   stage. Holds mstatus (MIE/MPIE), mie (MEIE/MTIE), mtvec, mepc and mcause,
//   and exposes a read-only mip built from two synchronized interrupt lines.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_reset        asynchronous active-high reset
//   i_csr_en       stage holds a SYSTEM-opcode instruction
//   i_csr_op       funct3 (001 RW, 010 RS, 011 RC, 101/110/111 immediate forms)
//   i_csr_addr     12-bit CSR address
//   i_csr_wdata    rs1 value or zero-extended zimm
//   i_mret         stage holds MRET
//   i_pc           PC of the instruction in this stage
//   i_pc_vld       stage holds a real instruction
//   i_stall        stage frozen, no architectural update
//   i_irq_ext      external interrupt request (asynchronous level)
//   i_irq_timer    timer interrupt request (asynchronous level)
//   o_csr_rdata    pre-write value of the addressed CSR (0 if unsupported)
//   o_redirect     one-cycle flush/redirect pulse
//   o_redirect_pc  redirect target
//   o_in_trap      handler-active flag

module csr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_csr_en,
  input  logic [2:0]  i_csr_op,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_mret,
  input  logic [31:0] i_pc,
  input  logic        i_pc_vld,
  input  logic        i_stall,
  input  logic        i_irq_ext,
  input  logic        i_irq_timer,
  output logic [31:0] o_csr_rdata,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_in_trap
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  logic        ext_s1, ext_s2;
  logic        tmr_s1, tmr_s2;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_meie, mie_mtie;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic        in_trap_q;

  logic        ext_hit, tmr_hit;
  logic        pending;
  logic        active;
  logic        take_trap;
  logic        do_mret;
  logic        csr_we;
  logic [31:0] csr_new;
  logic        unused_bits;

  // Two-flop synchronizers; they keep running through stalls and bubbles so
  // mip always reflects the request lines two edges later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ext_s1 <= 1'b0;
      ext_s2 <= 1'b0;
      tmr_s1 <= 1'b0;
      tmr_s2 <= 1'b0;
    end else begin
      ext_s1 <= i_irq_ext;
      ext_s2 <= ext_s1;
      tmr_s1 <= i_irq_timer;
      tmr_s2 <= tmr_s1;
    end
  end

  // Event decode: a trap pre-empts both MRET and a CSR write in the same
  // cycle, and nothing happens unless the stage holds a live, unstalled
  // instruction.
  always_comb begin
    ext_hit   = mie_meie & ext_s2;
    tmr_hit   = mie_mtie & tmr_s2;
    pending   = mstatus_mie & (ext_hit | tmr_hit);
    active    = i_pc_vld & ~i_stall;
    take_trap = pending & active;
    do_mret   = i_mret & active & ~take_trap;
    csr_we    = i_csr_en & (i_csr_op != 3'b000) & ~i_mret & active & ~take_trap;
  end

  // Combinational read of the old value; also the operand for set/clear.
  always_comb begin
    o_csr_rdata = 32'h0;
    case (i_csr_addr)
      ADDR_MSTATUS: o_csr_rdata = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
      ADDR_MIE:     o_csr_rdata = {20'h0, mie_meie, 3'b000, mie_mtie, 7'h00};
      ADDR_MTVEC:   o_csr_rdata = mtvec_q;
      ADDR_MEPC:    o_csr_rdata = mepc_q;
      ADDR_MCAUSE:  o_csr_rdata = mcause_q;
      ADDR_MIP:     o_csr_rdata = {20'h0, ext_s2, 3'b000, tmr_s2, 7'h00};
      default:      o_csr_rdata = 32'h0;
    endcase
  end

  // The low two funct3 bits select the operation for both register and
  // immediate forms; 100 (reserved) leaves the value unchanged.
  always_comb begin
    csr_new = o_csr_rdata;
    case (i_csr_op[1:0])
      2'b01:   csr_new = i_csr_wdata;
      2'b10:   csr_new = o_csr_rdata | i_csr_wdata;
      2'b11:   csr_new = o_csr_rdata & ~i_csr_wdata;
      default: csr_new = o_csr_rdata;
    endcase
  end

  // Architectural state. Trap and MRET are mutually exclusive by
  // construction, and a CSR write is only possible when neither occurs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec_q      <= {MTVEC_RST[31:2], 2'b00};
      mepc_q       <= 32'h0;
      mcause_q     <= 32'h0;
      in_trap_q    <= 1'b0;
    end else if (take_trap) begin
      mepc_q       <= {i_pc[31:2], 2'b00};
      mcause_q     <= ext_hit ? CAUSE_EXT : CAUSE_TIMER;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      in_trap_q    <= 1'b1;
    end else if (do_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
      in_trap_q    <= 1'b0;
    end else if (csr_we) begin
      case (i_csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie  <= csr_new[3];
          mstatus_mpie <= csr_new[7];
        end
        ADDR_MIE: begin
          mie_meie <= csr_new[11];
          mie_mtie <= csr_new[7];
        end
        ADDR_MTVEC:  mtvec_q  <= {csr_new[31:2], 2'b00};
        ADDR_MEPC:   mepc_q   <= {csr_new[31:2], 2'b00};
        ADDR_MCAUSE: mcause_q <= csr_new;
        default: ;
      endcase
    end
  end

  // Redirect is a pure function of this cycle's decode; reset forces it low
  // so a trap or MRET in flight at reset never leaks out.
  always_comb begin
    o_redirect    = 1'b0;
    o_redirect_pc = 32'h0;
    if (!i_reset) begin
      if (take_trap) begin
        o_redirect    = 1'b1;
        o_redirect_pc = mtvec_q;
      end else if (do_mret) begin
        o_redirect    = 1'b1;
        o_redirect_pc = mepc_q;
      end
    end
  end

  assign o_in_trap   = in_trap_q;
  assign unused_bits = ^i_pc[1:0];

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit
//   Directed bench for csr_unit: reset values, CSR read/write/set/clear,
//   trap entry, priority, MRET, blocked cycles and reset during a trap.

module tb_csr_unit;

  logic        clk;
  logic        reset;
  logic        csr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        mret;
  logic [31:0] pc;
  logic        pc_vld;
  logic        stall;
  logic        irq_ext;
  logic        irq_timer;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_trap;

  int pass_cnt = 0;
  int total_cnt = 0;

  csr_unit #(.MTVEC_RST(32'h0000_0100)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_csr_en      (csr_en),
    .i_csr_op      (csr_op),
    .i_csr_addr    (csr_addr),
    .i_csr_wdata   (csr_wdata),
    .i_mret        (mret),
    .i_pc          (pc),
    .i_pc_vld      (pc_vld),
    .i_stall       (stall),
    .i_irq_ext     (irq_ext),
    .i_irq_timer   (irq_timer),
    .o_csr_rdata   (csr_rdata),
    .o_redirect    (redirect),
    .o_redirect_pc (redirect_pc),
    .o_in_trap     (in_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_en = 1'b0;
    csr_op = 3'b000;
    csr_wdata = 32'h0;
    mret = 1'b0;
    stall = 1'b0;
    pc_vld = 1'b1;
  endtask

  task automatic drive_csr(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] wd);
    csr_en = 1'b1;
    csr_op = op;
    csr_addr = addr;
    csr_wdata = wd;
    #1;
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [31:0] val);
    csr_addr = addr;
    #1;
    val = csr_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle();
    reset = 1'b1;
    irq_ext = 1'b0;
    irq_timer = 1'b0;
    pc = 32'h0;
    tick();
    read_csr(12'h305, v);
    total_cnt++;
    if (v !== 32'h0000_0100) $display("[TB] FAIL rst_mtvec got=%h exp=%h", v, 32'h100);
    else pass_cnt++;
    read_csr(12'h300, v);
    total_cnt++;
    if (v !== 32'h0) $display("[TB] FAIL rst_mstatus got=%h exp=0", v);
    else pass_cnt++;
    total_cnt++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0 || in_trap !== 1'b0)
      $display("[TB] FAIL rst_outputs got=%b/%h/%b exp=0/0/0", redirect, redirect_pc, in_trap);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rw();
    logic [31:0] v;
    drive_csr(3'b001, 12'h305, 32'h0000_2003);
    total_cnt++;
    if (csr_rdata !== 32'h0000_0100) $display("[TB] FAIL rw_old_value got=%h exp=%h", csr_rdata, 32'h100);
    else pass_cnt++;
    tick();
    idle();
    read_csr(12'h305, v);
    total_cnt++;
    if (v !== 32'h0000_2000) $display("[TB] FAIL rw_mtvec got=%h exp=%h", v, 32'h2000);
    else pass_cnt++;
  endtask

  task automatic test_set_clear();
    logic [31:0] v;
    drive_csr(3'b010, 12'h304, 32'h0000_0800);
    tick();
    idle();
    read_csr(12'h304, v);
    total_cnt++;
    if (v !== 32'h0000_0800) $display("[TB] FAIL rs_mie got=%h exp=%h", v, 32'h800);
    else pass_cnt++;
    drive_csr(3'b011, 12'h304, 32'h0000_0800);
    tick();
    idle();
    read_csr(12'h304, v);
    total_cnt++;
    if (v !== 32'h0) $display("[TB] FAIL rc_mie got=%h exp=0", v);
    else pass_cnt++;
    drive_csr(3'b001, 12'h344, 32'hFFFF_FFFF);
    tick();
    idle();
    read_csr(12'h344, v);
    total_cnt++;
    if (v !== 32'h0) $display("[TB] FAIL mip_ignored got=%h exp=0", v);
    else pass_cnt++;
    drive_csr(3'b101, 12'h123, 32'h0000_001F);
    tick();
    idle();
    read_csr(12'h123, v);
    total_cnt++;
    if (v !== 32'h0) $display("[TB] FAIL unsupported_read got=%h exp=0", v);
    else pass_cnt++;
  endtask

  task automatic test_trap();
    logic [31:0] v;
    drive_csr(3'b001, 12'h305, 32'h0000_0200);
    tick();
    drive_csr(3'b001, 12'h304, 32'h0000_0800);
    tick();
    drive_csr(3'b110, 12'h300, 32'h0000_0008);
    tick();
    idle();
    pc = 32'h40;
    irq_ext = 1'b1;
    tick();
    total_cnt++;
    if (redirect !== 1'b0) $display("[TB] FAIL sync_one_edge got=%b exp=0", redirect);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200)
      $display("[TB] FAIL trap_redirect got=%b/%h exp=1/%h", redirect, redirect_pc, 32'h200);
    else pass_cnt++;
    tick();
    irq_ext = 1'b0;
    read_csr(12'h341, v);
    total_cnt++;
    if (v !== 32'h40) $display("[TB] FAIL trap_mepc got=%h exp=%h", v, 32'h40);
    else pass_cnt++;
    read_csr(12'h342, v);
    total_cnt++;
    if (v !== 32'h8000_000B) $display("[TB] FAIL trap_mcause got=%h exp=%h", v, 32'h8000000B);
    else pass_cnt++;
    read_csr(12'h300, v);
    total_cnt++;
    if (v !== 32'h80) $display("[TB] FAIL trap_mstatus got=%h exp=%h", v, 32'h80);
    else pass_cnt++;
    total_cnt++;
    if (in_trap !== 1'b1 || redirect !== 1'b0)
      $display("[TB] FAIL trap_flags got=%b/%b exp=1/0", in_trap, redirect);
    else pass_cnt++;
    tick();
    tick();
  endtask

  task automatic test_mret();
    logic [31:0] v;
    pc = 32'h200;
    mret = 1'b1;
    #1;
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h40)
      $display("[TB] FAIL mret_redirect got=%b/%h exp=1/%h", redirect, redirect_pc, 32'h40);
    else pass_cnt++;
    tick();
    idle();
    read_csr(12'h300, v);
    total_cnt++;
    if (v !== 32'h88) $display("[TB] FAIL mret_mstatus got=%h exp=%h", v, 32'h88);
    else pass_cnt++;
    total_cnt++;
    if (in_trap !== 1'b0 || redirect !== 1'b0)
      $display("[TB] FAIL mret_flags got=%b/%b exp=0/0", in_trap, redirect);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [31:0] v;
    drive_csr(3'b001, 12'h304, 32'h0000_0880);
    tick();
    idle();
    irq_ext = 1'b1;
    irq_timer = 1'b1;
    tick();
    tick();
    pc = 32'h80;
    mret = 1'b1;
    #1;
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200)
      $display("[TB] FAIL trap_over_mret got=%b/%h exp=1/%h", redirect, redirect_pc, 32'h200);
    else pass_cnt++;
    tick();
    idle();
    read_csr(12'h342, v);
    total_cnt++;
    if (v !== 32'h8000_000B) $display("[TB] FAIL ext_beats_timer got=%h exp=%h", v, 32'h8000000B);
    else pass_cnt++;
    read_csr(12'h341, v);
    total_cnt++;
    if (v !== 32'h80 || in_trap !== 1'b1)
      $display("[TB] FAIL prio_mepc got=%h/%b exp=%h/1", v, in_trap, 32'h80);
    else pass_cnt++;
    pc = 32'h84;
    mret = 1'b1;
    tick();
    idle();
    pc = 32'hC0;
    drive_csr(3'b001, 12'h341, 32'h0000_1234);
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200)
      $display("[TB] FAIL trap_over_csrrw got=%b/%h exp=1/%h", redirect, redirect_pc, 32'h200);
    else pass_cnt++;
    tick();
    idle();
    read_csr(12'h341, v);
    total_cnt++;
    if (v !== 32'hC0) $display("[TB] FAIL csrrw_suppressed got=%h exp=%h", v, 32'hC0);
    else pass_cnt++;
    irq_ext = 1'b0;
    tick();
    tick();
    pc = 32'hC4;
    mret = 1'b1;
    tick();
    idle();
    pc = 32'hC8;
    #1;
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200)
      $display("[TB] FAIL timer_redirect got=%b/%h exp=1/%h", redirect, redirect_pc, 32'h200);
    else pass_cnt++;
    tick();
    read_csr(12'h342, v);
    total_cnt++;
    if (v !== 32'h8000_0007) $display("[TB] FAIL timer_mcause got=%h exp=%h", v, 32'h80000007);
    else pass_cnt++;
  endtask

  task automatic test_blocked();
    logic [31:0] v;
    pc = 32'hCC;
    mret = 1'b1;
    tick();
    idle();
    stall = 1'b1;
    pc = 32'hD0;
    drive_csr(3'b001, 12'h341, 32'h0000_5554);
    total_cnt++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0)
      $display("[TB] FAIL stall_redirect got=%b/%h exp=0/0", redirect, redirect_pc);
    else pass_cnt++;
    tick();
    idle();
    read_csr(12'h341, v);
    total_cnt++;
    if (v !== 32'hC8 || in_trap !== 1'b0)
      $display("[TB] FAIL stall_state got=%h/%b exp=%h/0", v, in_trap, 32'hC8);
    else pass_cnt++;
    pc_vld = 1'b0;
    #1;
    total_cnt++;
    if (redirect !== 1'b0) $display("[TB] FAIL bubble_redirect got=%b exp=0", redirect);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (in_trap !== 1'b0) $display("[TB] FAIL bubble_state got=%b exp=0", in_trap);
    else pass_cnt++;
    pc_vld = 1'b1;
    #1;
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200)
      $display("[TB] FAIL release_redirect got=%b/%h exp=1/%h", redirect, redirect_pc, 32'h200);
    else pass_cnt++;
    tick();
    read_csr(12'h341, v);
    total_cnt++;
    if (v !== 32'hD0 || in_trap !== 1'b1)
      $display("[TB] FAIL release_state got=%h/%b exp=%h/1", v, in_trap, 32'hD0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_trap();
    logic [31:0] v;
    pc = 32'hD4;
    mret = 1'b1;
    tick();
    idle();
    pc = 32'hE0;
    #1;
    total_cnt++;
    if (redirect !== 1'b1) $display("[TB] FAIL pre_reset_pending got=%b exp=1", redirect);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0)
      $display("[TB] FAIL reset_redirect got=%b/%h exp=0/0", redirect, redirect_pc);
    else pass_cnt++;
    irq_timer = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    read_csr(12'h305, v);
    total_cnt++;
    if (v !== 32'h100) $display("[TB] FAIL reset_mtvec got=%h exp=%h", v, 32'h100);
    else pass_cnt++;
    read_csr(12'h341, v);
    total_cnt++;
    if (v !== 32'h0) $display("[TB] FAIL reset_mepc got=%h exp=0", v);
    else pass_cnt++;
    read_csr(12'h342, v);
    total_cnt++;
    if (v !== 32'h0) $display("[TB] FAIL reset_mcause got=%h exp=0", v);
    else pass_cnt++;
    read_csr(12'h300, v);
    total_cnt++;
    if (v !== 32'h0) $display("[TB] FAIL reset_mstatus got=%h exp=0", v);
    else pass_cnt++;
    read_csr(12'h304, v);
    total_cnt++;
    if (v !== 32'h0 || in_trap !== 1'b0 || redirect !== 1'b0)
      $display("[TB] FAIL reset_mie_flags got=%h/%b/%b exp=0/0/0", v, in_trap, redirect);
    else pass_cnt++;
  endtask

  initial begin
    csr_addr = 12'h0;
    test_reset();
    test_rw();
    test_set_clear();
    test_trap();
    test_mret();
    test_priority();
    test_blocked();
    test_reset_mid_trap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
